// File: rtl/pb_reset_sequencer.sv
// Pushbutton front end (sync, debounce, press/release edges) driving a staged reset release.
// Optional long-press detection is built only when PB_LONG_PRESS_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_HOLD    | reset button held (or just out of reset): all stages in reset
// S_STAGGER | releasing stages one by one, RST_GAP_CYCLES apart
// S_DONE    | every stage released, rst_done_o high
module pb_reset_sequencer #(
    parameter int NUM_PB            = 4,
    parameter int DEBOUNCE_CYCLES   = 50_000,
    parameter int RST_CH            = 0,
    parameter int NUM_RST           = 3,
    parameter int RST_GAP_CYCLES    = 50_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000
) (
    input  logic               SYS_CLK,
    input  logic               reset_n,
    input  logic [NUM_PB-1:0]  pb_n_i,
    output logic [NUM_PB-1:0]  pb_level_o,
    output logic [NUM_PB-1:0]  pb_press_o,
    output logic [NUM_PB-1:0]  pb_release_o,
    output logic [NUM_RST-1:0] rst_n_o,
    output logic               rst_done_o,
    output logic [NUM_PB-1:0]  long_press_o
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GAP_W = $clog2(RST_GAP_CYCLES + 1);
    localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(RST_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RST - 1);

    // Synchroniser stores the inverted button so the reset value means "not pressed"
    logic [NUM_PB-1:0] sync_meta;
    logic [NUM_PB-1:0] sync_q;

    always_ff @(posedge SYS_CLK or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= ~pb_n_i;
            sync_q    <= sync_meta;
        end
    end

    for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
        logic [DB_W-1:0] db_cnt;
        logic            level_q;
        logic            press_q;
        logic            rel_q;

        always_ff @(posedge SYS_CLK or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                if (sync_q[i] == level_q) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_MAX) begin
                    db_cnt  <= '0;
                    level_q <= sync_q[i];
                    press_q <= sync_q[i];
                    rel_q   <= ~sync_q[i];
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        assign pb_level_o[i]   = level_q;
        assign pb_press_o[i]   = press_q;
        assign pb_release_o[i] = rel_q;

`ifdef PB_LONG_PRESS_EN
        localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
        localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES - 1);
        localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_CYCLES);

        logic [LP_W-1:0] lp_cnt;
        logic            lp_pulse;

        // Counter parks at LP_SAT so a single press fires at most once
        always_ff @(posedge SYS_CLK or negedge reset_n) begin
            if (!reset_n) begin
                lp_cnt   <= '0;
                lp_pulse <= 1'b0;
            end else begin
                lp_pulse <= 1'b0;
                if (!level_q) begin
                    lp_cnt <= '0;
                end else if (lp_cnt == LP_MAX) begin
                    lp_cnt   <= LP_SAT;
                    lp_pulse <= 1'b1;
                end else if (lp_cnt != LP_SAT) begin
                    lp_cnt <= lp_cnt + 1'b1;
                end
            end
        end

        assign long_press_o[i] = lp_pulse;
`else
        assign long_press_o[i] = 1'b0;
`endif
    end

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STAGGER = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic [NUM_RST-1:0] rst_q,   rst_d;
    logic               done_q,  done_d;
    logic               rst_req;

    assign rst_req = pb_level_o[RST_CH];

    always_ff @(posedge SYS_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HOLD;
            idx_q   <= '0;
            gap_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        rst_d   = rst_q;
        done_d  = done_q;
        case (state_q)
            S_HOLD: begin
                idx_d  = '0;
                gap_d  = '0;
                rst_d  = '0;
                done_d = 1'b0;
                if (!rst_req) begin
                    state_d = S_STAGGER;
                end
            end
            S_STAGGER: begin
                if (rst_req) begin
                    state_d = S_HOLD;
                    idx_d   = '0;
                    gap_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                end else if (gap_q == GAP_MAX) begin
                    gap_d        = '0;
                    rst_d[idx_q] = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                if (rst_req) begin
                    state_d = S_HOLD;
                    idx_d   = '0;
                    gap_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_HOLD;
                idx_d   = '0;
                gap_d   = '0;
                rst_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign rst_n_o    = rst_q;
    assign rst_done_o = done_q;

endmodule

// File: tb/tb_pb_reset_sequencer.sv
// Directed bench for pb_reset_sequencer with small debounce/gap/long-press constants.
// Long-press expectations follow PB_LONG_PRESS_EN as seen by this compile.
module tb_pb_reset_sequencer;

    logic       SYS_CLK = 1'b0;
    logic       reset_n;
    logic [3:0] pb_n_i;
    logic [3:0] pb_level_o;
    logic [3:0] pb_press_o;
    logic [3:0] pb_release_o;
    logic [2:0] rst_n_o;
    logic       rst_done_o;
    logic [3:0] long_press_o;

    int n_pass  = 0;
    int n_total = 0;

    int press1_cnt = 0;
    int rel1_cnt   = 0;
    int lp2_cnt    = 0;
    int lp_any_cnt = 0;
    int snap_p, snap_r, snap_l;

    pb_reset_sequencer #(
        .NUM_PB(4),
        .DEBOUNCE_CYCLES(4),
        .RST_CH(0),
        .NUM_RST(3),
        .RST_GAP_CYCLES(8),
        .LONG_PRESS_CYCLES(20)
    ) dut (
        .SYS_CLK(SYS_CLK),
        .reset_n(reset_n),
        .pb_n_i(pb_n_i),
        .pb_level_o(pb_level_o),
        .pb_press_o(pb_press_o),
        .pb_release_o(pb_release_o),
        .rst_n_o(rst_n_o),
        .rst_done_o(rst_done_o),
        .long_press_o(long_press_o)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    always @(negedge SYS_CLK) begin
        press1_cnt = press1_cnt + int'(pb_press_o[1]);
        rel1_cnt   = rel1_cnt + int'(pb_release_o[1]);
        lp2_cnt    = lp2_cnt + int'(long_press_o[2]);
        lp_any_cnt = lp_any_cnt + int'(|long_press_o);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        pb_n_i  = 4'hF;
        tick(3);
        chk("reset_level", 32'(pb_level_o), 32'h0);
        chk("reset_rst", 32'(rst_n_o), 32'h0);
        chk("reset_done", 32'(rst_done_o), 32'h0);
        chk("reset_pulses", 32'({pb_press_o, pb_release_o, long_press_o}), 32'h0);

        // Power-up stagger: STAGGER entered on edge 1, stages at edges 9/17/25
        reset_n = 1'b1;
        tick(8);
        chk("pu_e8", 32'(rst_n_o), 32'h0);
        tick(1);
        chk("pu_e9", 32'(rst_n_o), 32'h1);
        tick(7);
        chk("pu_e16", 32'(rst_n_o), 32'h1);
        tick(1);
        chk("pu_e17", 32'(rst_n_o), 32'h3);
        tick(7);
        chk("pu_e24_rst", 32'(rst_n_o), 32'h3);
        chk("pu_e24_done", 32'(rst_done_o), 32'h0);
        tick(1);
        chk("pu_e25_rst", 32'(rst_n_o), 32'h7);
        chk("pu_e25_done", 32'(rst_done_o), 32'h1);

        // 3-cycle glitch on channel 1 must be filtered
        snap_p = press1_cnt; snap_r = rel1_cnt;
        pb_n_i[1] = 1'b0;
        tick(3);
        pb_n_i[1] = 1'b1;
        tick(10);
        chk("glitch_level", 32'(pb_level_o[1]), 32'h0);
        chk("glitch_press", 32'(press1_cnt - snap_p), 32'h0);
        chk("glitch_rel", 32'(rel1_cnt - snap_r), 32'h0);

        // 12-cycle press on channel 1: level at edge 6, release 6 edges after letting go
        snap_p = press1_cnt; snap_r = rel1_cnt;
        pb_n_i[1] = 1'b0;
        tick(5);
        chk("press_e5_level", 32'(pb_level_o[1]), 32'h0);
        tick(1);
        chk("press_e6_level", 32'(pb_level_o[1]), 32'h1);
        chk("press_e6_pulse", 32'(pb_press_o[1]), 32'h1);
        tick(1);
        chk("press_e7_pulse", 32'(pb_press_o[1]), 32'h0);
        tick(5);
        pb_n_i[1] = 1'b1;
        tick(5);
        chk("rel_e5_level", 32'(pb_level_o[1]), 32'h1);
        chk("rel_e5_pulse", 32'(pb_release_o[1]), 32'h0);
        tick(1);
        chk("rel_e6_level", 32'(pb_level_o[1]), 32'h0);
        chk("rel_e6_pulse", 32'(pb_release_o[1]), 32'h1);
        tick(1);
        chk("rel_e7_pulse", 32'(pb_release_o[1]), 32'h0);
        chk("press_count", 32'(press1_cnt - snap_p), 32'h1);
        chk("rel_count", 32'(rel1_cnt - snap_r), 32'h1);
        chk("rst_untouched", 32'(rst_n_o), 32'h7);

        // 40-cycle hold on channel 2: level at edge 6, long press at edge 26
        snap_l = lp2_cnt;
        pb_n_i[2] = 1'b0;
        tick(6);
        chk("lp_level", 32'(pb_level_o[2]), 32'h1);
        tick(19);
        chk("lp_e25", 32'(long_press_o[2]), 32'h0);
        tick(1);
`ifdef PB_LONG_PRESS_EN
        chk("lp_e26", 32'(long_press_o[2]), 32'h1);
`else
        chk("lp_e26", 32'(long_press_o[2]), 32'h0);
`endif
        tick(1);
        chk("lp_e27", 32'(long_press_o[2]), 32'h0);
        tick(13);
        pb_n_i[2] = 1'b1;
        tick(10);
        chk("lp_released", 32'(pb_level_o[2]), 32'h0);
`ifdef PB_LONG_PRESS_EN
        chk("lp_count", 32'(lp2_cnt - snap_l), 32'h1);
`else
        chk("lp_count", 32'(lp2_cnt - snap_l), 32'h0);
`endif

        // Reset button pressed 10 cycles while DONE: HOLD one edge after level rises
        pb_n_i[0] = 1'b0;
        tick(6);
        chk("rb_e6_level", 32'(pb_level_o[0]), 32'h1);
        chk("rb_e6_rst", 32'(rst_n_o), 32'h7);
        tick(1);
        chk("rb_e7_rst", 32'(rst_n_o), 32'h0);
        chk("rb_e7_done", 32'(rst_done_o), 32'h0);
        tick(3);
        pb_n_i[0] = 1'b1;
        tick(6);
        chk("rb_e16_level", 32'(pb_level_o[0]), 32'h0);
        chk("rb_e16_rst", 32'(rst_n_o), 32'h0);
        tick(8);
        chk("rb_e24", 32'(rst_n_o), 32'h0);
        tick(1);
        chk("rb_e25", 32'(rst_n_o), 32'h1);
        tick(7);
        chk("rb_e32", 32'(rst_n_o), 32'h1);
        tick(1);
        chk("rb_e33", 32'(rst_n_o), 32'h3);
        tick(7);
        chk("rb_e40_done", 32'(rst_done_o), 32'h0);
        tick(1);
        chk("rb_e41_rst", 32'(rst_n_o), 32'h7);
        chk("rb_e41_done", 32'(rst_done_o), 32'h1);

        // reset_n mid-debounce (counter at 2): immediate clear, full latency afterwards
        pb_n_i[1] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        #1;
        chk("ar_rst", 32'(rst_n_o), 32'h0);
        chk("ar_done", 32'(rst_done_o), 32'h0);
        chk("ar_level", 32'(pb_level_o), 32'h0);
        chk("ar_pulses", 32'({pb_press_o, pb_release_o, long_press_o}), 32'h0);
        tick(3);
        chk("ar_held_level", 32'(pb_level_o[1]), 32'h0);
        reset_n = 1'b1;
        tick(5);
        chk("ar_e5_level", 32'(pb_level_o[1]), 32'h0);
        tick(1);
        chk("ar_e6_level", 32'(pb_level_o[1]), 32'h1);
        chk("ar_e6_press", 32'(pb_press_o[1]), 32'h1);
        pb_n_i[1] = 1'b1;
        tick(10);

`ifndef PB_LONG_PRESS_EN
        chk("lp_never", 32'(lp_any_cnt), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pb_reset_sequencer.md
PB_RESET_SEQUENCER -- requirements
Module: pb_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_PB, default 4: number of pushbutton channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50_000: stable-input cycles required before a level change (1 ms at 50 MHz); legal range 1 or more.
REQ-003 SHALL have parameter RST_CH, default 0: index of the channel acting as the reset request.
REQ-004 SHALL have parameter NUM_RST, default 3: number of staged reset outputs; legal range 1 or more.
REQ-005 SHALL have parameter RST_GAP_CYCLES, default 50_000: cycles between successive stage releases; legal range 1 or more.
REQ-006 SHALL have parameter LONG_PRESS_CYCLES, default 100_000_000: hold time for a long press.
REQ-007 SHALL have port SYS_CLK, input, width 1: the single clock.
REQ-008 SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-009 SHALL have port pb_n_i, input, width NUM_PB: raw asynchronous buttons; 0 means pressed.
REQ-010 SHALL have port pb_level_o, output, width NUM_PB: debounced state; 1 means pressed.
REQ-011 SHALL have port pb_press_o, output, width NUM_PB: one-cycle pulse when pb_level_o rises.
REQ-012 SHALL have port pb_release_o, output, width NUM_PB: one-cycle pulse when pb_level_o falls.
REQ-013 SHALL have port rst_n_o, output, width NUM_RST: staged active-low resets.
REQ-014 SHALL have port rst_done_o, output, width 1: 1 when all stages are released.
REQ-015 SHALL have port long_press_o, output, width NUM_PB: one-cycle long-press pulse.

Function
REQ-016 Each pb_n_i bit SHALL pass through a 2-FF synchroniser and be inverted to give sync[i], where 1 means pressed.
REQ-017 Per-channel debounce counter, width $clog2(DEBOUNCE_CYCLES+1):
- increments each cycle in which sync[i] differs from pb_level_o[i];
- clears in any cycle where they are equal;
- on reaching DEBOUNCE_CYCLES-1 while still different, pb_level_o[i] toggles on the next edge and the counter clears.
REQ-018 Press-to-level latency SHALL be exactly 2+DEBOUNCE_CYCLES cycles; any pulse shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no change.
REQ-019 pb_press_o[i] / pb_release_o[i] SHALL be registered, high for exactly the single cycle after pb_level_o[i] changes; channels are independent and simultaneous events are all reported.
REQ-020 Sequencer FSM with states HOLD, STAGGER and DONE, a stage index idx, and a gap counter of width $clog2(RST_GAP_CYCLES+1).
REQ-021 HOLD: all rst_n_o=0, rst_done_o=0, idx=0, counter=0; move to STAGGER when pb_level_o[RST_CH]=0.
REQ-022 STAGGER: counter increments; at RST_GAP_CYCLES-1, rst_n_o[idx] is set to 1 and the counter clears.
- if idx=NUM_RST-1, move to DONE and set rst_done_o=1;
- otherwise idx increments.
REQ-023 Stage k SHALL rise exactly (k+1)*RST_GAP_CYCLES cycles after STAGGER entry; released stages stay 1.
REQ-024 In STAGGER or DONE, pb_level_o[RST_CH]=1 SHALL force HOLD on the next edge, dropping all rst_n_o and rst_done_o together; a release sequence always restarts from stage 0.
REQ-025 When NUM_RST=1, STAGGER releases the single stage and enters DONE in the same transition.

Reset
REQ-026 While reset_n=0, asynchronously:
- synchroniser flops = 0 (not pressed);
- pb_level_o = 0; pb_press_o, pb_release_o and long_press_o = 0;
- debounce and long-press counters = 0;
- FSM = HOLD; rst_n_o = 0; rst_done_o = 0.
REQ-027 After reset_n deasserts with no button held, the FSM SHALL enter STAGGER on the first edge (cycle 1).
REQ-028 reset_n asserted mid-debounce or mid-stagger SHALL abandon all progress with no output pulse.

Configuration
REQ-029 Macro PB_LONG_PRESS_EN controls long-press detection.
- Defined: a per-channel counter runs while pb_level_o[i]=1 and clears when it is 0; long_press_o[i] pulses one cycle LONG_PRESS_CYCLES cycles after pb_level_o[i] rose, at most once per press.
- Undefined: the port remains, long_press_o is constant 0, and no long-press counters are built.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, RST_GAP_CYCLES=8, NUM_RST=3, LONG_PRESS_CYCLES=20.
REQ-030 Release reset_n with pb_n_i=4'hF -> rst_n_o bits 0, 1 and 2 rise after cycles 8, 16 and 24 respectively; rst_done_o rises with bit 2.
REQ-031 Drive pb_n_i[1]=0 for 3 cycles -> pb_level_o[1] stays 0 and no press or release pulse occurs.
REQ-032 Drive pb_n_i[1]=0 for 12 cycles -> pb_level_o[1] rises 6 cycles after the first low edge with a one-cycle pb_press_o[1]; after release, pb_release_o[1] pulses once 6 cycles later.
REQ-033 Press RST_CH for 10 cycles once rst_n_o[0]=1 -> all rst_n_o and rst_done_o are 0 the cycle after pb_level_o[0] rises; after release, the staged sequence restarts at 8/16/24 cycles.
REQ-034 With the macro defined, hold pb_n_i[2]=0 for 40 cycles -> exactly one long_press_o[2] pulse, 20 cycles after pb_level_o[2] rises; with the macro undefined, long_press_o stays 0.
REQ-035 Assert reset_n=0 with a debounce counter at 2 -> all outputs return to reset values immediately, and a full 6-cycle latency applies afterwards.
